// File: rtl/axis_ma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_ma_pkg
// Brief    : Shared widths and defaults for the AXI-Stream moving-average stage.
// Revision : 1.0
// ============================================================================
package axis_ma_pkg;

    localparam int c_AXIS_W           = 16;
    localparam int c_DATA_W_DEFAULT   = 12;
    localparam int c_LOG2_LEN_DEFAULT = 3;

    // Running-sum width: N * max(sample) always fits in DATA_W + LOG2_LEN bits.
    function automatic int sum_width(input int data_w, input int log2_len);
        return data_w + log2_len;
    endfunction

    localparam int c_SUM_W_DEFAULT = sum_width(c_DATA_W_DEFAULT, c_LOG2_LEN_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/ma_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : ma_delay_line
// Brief    : N-entry register circular buffer; reads the oldest entry at the
//            write pointer and replaces it on write. Fully cleared by reset.
// Revision : 1.0
// ============================================================================
module ma_delay_line
    import axis_ma_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int LOG2_LEN = c_LOG2_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_N = 1 << LOG2_LEN;

    logic [DATA_W-1:0]   r_mem [c_N];
    logic [LOG2_LEN-1:0] r_wr_ptr;

    // Pointer width equals log2(N), so wrap modulo N comes for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_N; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + LOG2_LEN'(1);
        end
    end

    assign o_rd_data = r_mem[r_wr_ptr];

endmodule
`default_nettype wire

// File: rtl/axis_moving_average.sv
`default_nettype none
// ============================================================================
// Module   : axis_moving_average
// Brief    : Boxcar moving average over the last 2^LOG2_LEN AXI-Stream samples,
//            one output per input, tlast passed through, full backpressure.
// Revision : 1.0
// ============================================================================
module axis_moving_average
    import axis_ma_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int LOG2_LEN = c_LOG2_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [c_AXIS_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [c_AXIS_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                window_full
);

    localparam int c_SUM_W = sum_width(DATA_W, LOG2_LEN);

    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [c_AXIS_W-1:0] r_m_tdata;
    logic [c_SUM_W-1:0]  r_sum;
    logic [LOG2_LEN:0]   r_fill_cnt;

    logic                w_accept;
    logic [DATA_W-1:0]   w_x;
    logic [DATA_W-1:0]   w_old;
    logic [c_SUM_W-1:0]  w_sum_next;
    logic                w_unused;

    assign s_axis_tready = !r_m_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_x           = s_axis_tdata[DATA_W-1:0];
    assign w_unused      = ^s_axis_tdata[c_AXIS_W-1:DATA_W];

    ma_delay_line #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_data (w_x),
        .o_rd_data (w_old)
    );

    // Modular arithmetic is exact here: the true result is never negative
    // and never exceeds c_SUM_W bits.
    assign w_sum_next = r_sum + c_SUM_W'(w_x) - c_SUM_W'(w_old);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_fill_cnt <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
        end else if (w_accept) begin
            r_sum      <= w_sum_next;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= s_axis_tlast;
            r_m_tdata  <= c_AXIS_W'(w_sum_next[c_SUM_W-1:LOG2_LEN]);
            if (!r_fill_cnt[LOG2_LEN]) begin
                r_fill_cnt <= r_fill_cnt + (LOG2_LEN + 1)'(1);
            end
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Counter saturates at exactly N = 2^LOG2_LEN, so its MSB is the full flag.
    assign window_full   = r_fill_cnt[LOG2_LEN];
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_tdata;

endmodule
`default_nettype wire

// File: tb/tb_axis_moving_average.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_moving_average
// Brief    : Directed self-checking bench for axis_moving_average with N = 4.
// Revision : 1.0
// ============================================================================
module tb_axis_moving_average;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        window_full;

    int n_checks;
    int n_fail;

    axis_moving_average #(
        .DATA_W   (12),
        .LOG2_LEN (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .window_full   (window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for one clock; outputs are then sampled 1 time unit later.
    task automatic push(input logic [15:0] x, input logic last);
        s_axis_tdata  = x;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic apply_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b l=%b d=%h want v=0 l=0 d=0000",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        n_checks++;
        if (window_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_window_full: got %b want 0", window_full);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_constant();
        logic [15:0] exp_d [6];
        exp_d = '{16'h200, 16'h400, 16'h600, 16'h800, 16'h800, 16'h800};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (s_axis_tready !== 1'b1) begin
                n_fail++; $display("FAIL const_tready[%0d]: got %b want 1", i, s_axis_tready);
            end
            push(16'h0800, 1'b0);
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[i]) begin
                n_fail++;
                $display("FAIL const_out[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, m_axis_tvalid, m_axis_tdata, exp_d[i]);
            end
            n_checks++;
            if (window_full !== (i >= 3)) begin
                n_fail++;
                $display("FAIL const_window_full[%0d]: got %b want %b", i, window_full, (i >= 3));
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL const_drain_tvalid: got %b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_step();
        logic [15:0] din [9];
        logic [15:0] exp_d [9];
        din   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFF, 16'hFFF, 16'hFFF, 16'hFFF, 16'hFFF};
        exp_d = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h3FF, 16'h7FF, 16'hBFF, 16'hFFF, 16'hFFF};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            push(din[i], 1'b0);
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[i]) begin
                n_fail++;
                $display("FAIL step_out[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, m_axis_tvalid, m_axis_tdata, exp_d[i]);
            end
        end
    endtask

    task automatic test_mask();
        apply_reset();
        push(16'hF123, 1'b0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0048) begin
            n_fail++;
            $display("FAIL mask_out: got v=%b d=%h want v=1 d=0048", m_axis_tvalid, m_axis_tdata);
        end
    endtask

    task automatic test_tlast();
        logic [15:0] exp_d [5];
        exp_d = '{16'h100, 16'h200, 16'h300, 16'h400, 16'h400};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push(16'h0400, (i == 4));
            n_checks++;
            if (m_axis_tdata !== exp_d[i] || m_axis_tlast !== (i == 4)) begin
                n_fail++;
                $display("FAIL tlast_out[%0d]: got d=%h l=%b want d=%h l=%b",
                         i, m_axis_tdata, m_axis_tlast, exp_d[i], (i == 4));
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL tlast_drain_tvalid: got %b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        m_axis_tready = 1'b0;
        push(16'h0800, 1'b1);
        // Second sample waits behind the stalled output.
        s_axis_tdata  = 16'h0400;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 ||
                m_axis_tdata !== 16'h200 || m_axis_tlast !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h l=%b want rdy=0 v=1 d=0200 l=1",
                         i, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
            end
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_tready: got %b want 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h300 || m_axis_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_after[0]: got v=%b d=%h l=%b want v=1 d=0300 l=0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        push(16'h0400, 1'b0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h400) begin
            n_fail++;
            $display("FAIL stall_after[1]: got v=%b d=%h want v=1 d=0400", m_axis_tvalid, m_axis_tdata);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_dup: got tvalid=%b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] exp_d [4];
        exp_d = '{16'h100, 16'h200, 16'h300, 16'h400};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push(16'h0800, 1'b0);
        end
        // A sample held valid across the reset pulse must be dropped.
        s_axis_tdata  = 16'h0800;
        s_axis_tvalid = 1'b1;
        rst_n         = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0 || window_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got v=%b d=%h wf=%b want v=0 d=0000 wf=0",
                     m_axis_tvalid, m_axis_tdata, window_full);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        rst_n         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'h0400, 1'b0);
            n_checks++;
            if (m_axis_tdata !== exp_d[i] || window_full !== (i == 3)) begin
                n_fail++;
                $display("FAIL midreset_out[%0d]: got d=%h wf=%b want d=%h wf=%b",
                         i, m_axis_tdata, window_full, exp_d[i], (i == 3));
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_constant();
        test_step();
        test_mask();
        test_tlast();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_moving_average.md
# axis_moving_average

Downstream smoothing stage for the MCP3202 sample stream. It accepts 16-bit AXI-Stream samples carrying a right-justified 12-bit ADC code with packet tlast, and emits one boxcar moving average per input sample over the last 2^LOG2_LEN samples. It preserves tlast and honours full AXI-Stream backpressure. It sits between the sample/tlast stream source and the DMA/consumer interface.

## Interface
Parameters:
- DATA_W, 12: number of valid LSBs in s_axis_tdata; upper bits are ignored.
- LOG2_LEN, 3: log2 of the window length N. Legal range is 1..5.

Ports:
- clk  in  1: single clock for all logic.
- rst_n  in  1: asynchronous, active-low reset.
- s_axis_tdata  in  16: input sample; only bits [DATA_W-1:0] are used.
- s_axis_tvalid  in  1: input valid.
- s_axis_tready  out  1: input ready.
- s_axis_tlast  in  1: end-of-packet marker.
- m_axis_tdata  out  16: average, zero-extended from DATA_W bits.
- m_axis_tvalid  out  1: output valid.
- m_axis_tready  in  1: downstream ready.
- m_axis_tlast  out  1: tlast of the sample that produced this average.
- window_full  out  1: high once N samples have been accepted since reset.

## Operation
- State held by the block:
  - delay line of N entries, each DATA_W bits, all zero at reset;
  - write pointer wr_ptr, LOG2_LEN bits;
  - running sum, DATA_W+LOG2_LEN bits, unsigned;
  - fill counter that saturates at N;
  - output register holding tdata, tvalid and tlast.
- Accept condition: s_axis_tvalid && s_axis_tready.
- On each accept, with x = s_axis_tdata[DATA_W-1:0]:
  - sum_next = sum + x - line[wr_ptr]; this uses the old entry, read before the write.
  - line[wr_ptr] <= x.
  - wr_ptr <= wr_ptr + 1, wrapping modulo N.
  - Output register tdata <= sum_next >> LOG2_LEN, using floor (truncation) with no rounding.
  - Output register tlast <= s_axis_tlast, and tvalid <= 1.
- During warm-up the zero-initialised entries take part in the average, so early outputs ramp up (for example x/N, then 2x/N, and so on).
- tlast has no effect on the arithmetic. The window runs continuously across packet boundaries.
- window_full rises in the cycle after the Nth accept. It stays high until the next reset.
- There is no arithmetic overflow: the sum is at most N*(2^DATA_W - 1), which fits in DATA_W+LOG2_LEN bits.

## Timing
- Reset values while rst_n is low (asynchronous assert):
  - s_axis_tready = 1;
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0;
  - window_full = 0, sum = 0, wr_ptr = 0, all delay-line entries = 0.
- Latency: one clock from accept to the result appearing on m_axis_tvalid and m_axis_tdata.
- Throughput: one sample per clock when m_axis_tready is held high.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. This is combinational from m_axis_tready and gives a one-deep pipeline with no bubble.
- When m_axis_tvalid && !m_axis_tready:
  - the output register holds tdata and tlast stable;
  - s_axis_tready is 0;
  - no internal state changes.
- Simultaneous output handshake and new accept in the same cycle: the output register is overwritten with the new result and tvalid stays 1.
- Output handshake with no new accept: tvalid goes to 0 in the next cycle.
- Reset mid-stream: any pending output is discarded and the window restarts empty. A sample presented during reset is not accepted.

## Structure
- Shared package axis_ma_pkg holds:
  - default DATA_W and LOG2_LEN;
  - the derived SUM_W = DATA_W + LOG2_LEN;
  - the AXIS data width constant of 16.
- One natural sub-module is ma_delay_line. It is the N-entry register-based circular buffer with an async-clearable array, providing the read-old/write-new port and wr_ptr wrap.
- Registers are used rather than BRAM so that reset can clear the buffer.

## Test plan
All scenarios use LOG2_LEN=2 (N=4) and DATA_W=12 unless noted.
- Constant 0x0800 for 6 samples with tready=1 -> outputs 0x200, 0x400, 0x600, 0x800, 0x800, 0x800; window_full rises after the 4th accept; one-cycle latency on every sample.
- Step input 0,0,0,0 then 0x0FFF repeated -> outputs 0, 0, 0, 0, 0x3FF, 0x7FF, 0xBFF, 0xFFF, 0xFFF; checks floor division with no rounding.
- Input 0xF123 -> the value is treated as 0x123, and the first output is 0x048.
- 5 samples of 0x400 with tlast on the 5th -> only the 5th output has tlast=1, with tdata 0x400.
- Backpressure: hold m_axis_tready=0 for 5 cycles while tvalid=1 -> s_axis_tready=0, m_axis_tdata/tlast stable, no sample lost or duplicated; after release the sequence is identical to the unstalled run.
- Reset mid-stream: accept 3 samples of 0x800, pulse rst_n low for 1 cycle, then feed 0x400 -> first output is 0x100 (not 0x700); window_full is 0 until 4 further accepts.
